// File: rtl/cpu_control_seq.sv
// Control sequencer for a small load/store CPU: fetch, execute, memory and halt
// states, with sticky fault flags, a bus timeout and a retired-instruction counter.
module cpu_control_seq #(
   parameter int DW         = 16,
   parameter int IMM_SIGNED = 1,
   parameter int TIMEOUT    = 15,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      ir,
   input  logic             zero,
   input  logic             mem_ack,
   output logic [1:0]       ps,
   output logic             ir_l,
   output logic [2:0]       aa,
   output logic [2:0]       ba,
   output logic [2:0]       da,
   output logic             wr,
   output logic [4:0]       fs,
   output logic             cin,
   output logic             mux_k,
   output logic             mux_mem,
   output logic [DW-1:0]    k,
   output logic             mem_req,
   output logic             mem_we,
   output logic             halted,
   output logic [1:0]       fault,
   output logic [CNT_W-1:0] retired
);

   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_FETCH,
      S_EXEC,
      S_MEM,
      S_HALT
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [TO_W-1:0]   r_to;
   logic [CNT_W-1:0]  r_retired;
   logic [1:0]        r_fault;

   logic [3:0]        w_op;
   logic [2:0]        w_rd;
   logic [2:0]        w_ra;
   logic [2:0]        w_rb;
   logic [DW-1:0]     w_kExt;
   logic              w_toLast;
   logic              w_timeout;
   logic              w_retire;
   logic              w_illegal;

   assign w_op     = ir[15:12];
   assign w_rd     = ir[11:9];
   assign w_ra     = ir[8:6];
   assign w_rb     = ir[5:3];
   assign w_toLast = (r_to == TO_LAST);
   assign fault    = r_fault;
   assign retired  = r_retired;

   // Immediate extension written bitwise so DW == 8 needs no zero-width replication.
   always_comb begin
      w_kExt      = '0;
      w_kExt[7:0] = ir[7:0];
      for (int i = 8; i < DW; i++) begin
         w_kExt[i] = (IMM_SIGNED != 0) && ir[7];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_timeout = 1'b0;
      w_retire  = 1'b0;
      w_illegal = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (mem_ack) begin
               w_next = S_EXEC;
            end else if (w_toLast) begin
               w_next    = S_HALT;
               w_timeout = 1'b1;
            end
         end
         S_EXEC: begin
            w_illegal = (w_op >= 4'b1100) && (w_op <= 4'b1110);
            case (w_op)
               4'b1000, 4'b1001: w_next = S_MEM;
               4'b1111:          w_next = S_HALT;
               default: begin
                  w_next   = S_FETCH;
                  w_retire = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            if (mem_ack) begin
               w_next   = S_FETCH;
               w_retire = 1'b1;
            end else if (w_toLast) begin
               w_next    = S_HALT;
               w_timeout = 1'b1;
            end
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_FETCH;
      endcase
   end

   // Timeout counter only runs through no-ack cycles in FETCH/MEM; every other cycle clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_to      <= '0;
         r_retired <= '0;
         r_fault   <= 2'b00;
      end else begin
         if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ack && !w_timeout) begin
            r_to <= r_to + 1'b1;
         end else begin
            r_to <= '0;
         end
         if (w_retire) begin
            r_retired <= r_retired + 1'b1;
         end
         if (w_illegal) begin
            r_fault[0] <= 1'b1;
         end
         if (w_timeout) begin
            r_fault[1] <= 1'b1;
         end
      end
   end

   always_comb begin
      ps      = 2'b00;
      ir_l    = 1'b0;
      aa      = 3'd0;
      ba      = 3'd0;
      da      = 3'd0;
      wr      = 1'b0;
      fs      = 5'b00000;
      cin     = 1'b0;
      mux_k   = 1'b0;
      mux_mem = 1'b0;
      k       = '0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      halted  = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_req = 1'b1;
            ir_l    = mem_ack;
         end
         S_EXEC: begin
            k = w_kExt;
            case (w_op)
               4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
                  aa = w_ra;
                  ba = w_rb;
                  da = w_rd;
                  wr = 1'b1;
                  ps = 2'b01;
                  case (w_op)
                     4'b0001: fs = 5'b00010;
                     4'b0010: begin
                        fs  = 5'b00101;
                        cin = 1'b1;
                     end
                     4'b0011: fs = 5'b01000;
                     4'b0100: fs = 5'b01010;
                     default: fs = 5'b01100;
                  endcase
               end
               4'b0110: begin
                  aa    = w_rd;
                  da    = w_rd;
                  mux_k = 1'b1;
                  fs    = 5'b00010;
                  wr    = 1'b1;
                  ps    = 2'b01;
               end
               4'b0111: begin
                  da    = w_rd;
                  mux_k = 1'b1;
                  fs    = 5'b11000;
                  wr    = 1'b1;
                  ps    = 2'b01;
               end
               4'b1000, 4'b1001: aa = w_ra;
               4'b1010:          ps = zero ? 2'b10 : 2'b01;
               4'b1011: begin
                  aa = w_ra;
                  ps = 2'b11;
               end
               4'b1111:          ps = 2'b00;
               default:          ps = 2'b01;
            endcase
         end
         S_MEM: begin
            mem_req = 1'b1;
            aa      = w_ra;
            if (w_op[0]) begin
               ba     = w_rb;
               mem_we = 1'b1;
               if (mem_ack) begin
                  ps = 2'b01;
               end
            end else begin
               da = w_rd;
               if (mem_ack) begin
                  wr      = 1'b1;
                  mux_mem = 1'b1;
                  ps      = 2'b01;
               end
            end
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/cpu_control_seq.md
CPU_CONTROL_SEQ -- requirements
Module: cpu_control_seq

Interface
REQ-001 The block SHALL have exactly these parameters:
- DW, 16, data/immediate width (>=8).
- IMM_SIGNED, 1, 1 = sign-extend imm8 to DW, 0 = zero-extend.
- TIMEOUT, 15, max consecutive no-ack cycles in FETCH/MEM (>=1).
- CNT_W, 16, width of retired-instruction counter.

REQ-002 The block SHALL have exactly these ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ir  in  16  instruction register contents.
- zero  in  1  ALU zero flag.
- mem_ack  in  1  memory transfer complete this cycle.
- ps  out  2  PC select: 00 hold, 01 increment, 10 PC+k, 11 PC<=A bus.
- ir_l  out  1  load IR from memory data.
- aa  out  3  register A read address.
- ba  out  3  register B read address.
- da  out  3  register write address.
- wr  out  1  register write enable.
- fs  out  5  ALU function select.
- cin  out  1  ALU carry in.
- mux_k  out  1  ALU B operand = k.
- mux_mem  out  1  writeback data = memory.
- k  out  DW  extended immediate.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write (valid with mem_req).
- halted  out  1  in HALT state.
- fault  out  2  sticky: [0] illegal opcode, [1] memory timeout.
- retired  out  CNT_W  retired-instruction count.

Function
REQ-003 States SHALL be FETCH, EXEC, MEM, HALT; fields op=ir[15:12], rd=ir[11:9], ra=ir[8:6], rb=ir[5:3], imm8=ir[7:0].
REQ-004 Every control output SHALL be 0 (ps=00) unless asserted below; k SHALL equal ext(imm8) in EXEC and 0 otherwise.
REQ-005 FETCH: mem_req=1, mem_we=0; on mem_ack, ir_l=1 that cycle and next state EXEC; else stay.
REQ-006 EXEC, ops 0001-0101 (ADD,SUB,AND,OR,XOR): aa=ra, ba=rb, da=rd, wr=1, ps=01; fs=00010, 00101 with cin=1, 01000, 01010, 01100 respectively.
REQ-007 EXEC, 0110 ADDI: aa=rd, da=rd, mux_k=1, fs=00010, wr=1, ps=01; 0111 LDI: da=rd, mux_k=1, fs=11000 (pass B), wr=1, ps=01.
REQ-008 EXEC, 1000 LD / 1001 ST: aa=ra, no write, ps=00, next MEM.
REQ-009 MEM: mem_req=1, aa=ra; LD: da=rd, on ack wr=1, mux_mem=1, ps=01; ST: ba=rb, mem_we=1, on ack ps=01; on ack next FETCH, else stay.
REQ-010 EXEC, 1010 BZ: ps=10 if zero=1, else ps=01; 1011 JMP: aa=ra, ps=11; 0000 NOP: ps=01.
REQ-011 EXEC, 1100-1110: treated as NOP (ps=01), fault[0] set.
REQ-012 EXEC, 1111 HALT: ps=00, next HALT; HALT is absorbing until rst, halted=1, mem_req=0.
REQ-013 All EXEC cases except LD/ST/HALT SHALL return to FETCH next cycle; ALU-op latency = ack cycle + 1.
REQ-014 Timeout counter SHALL clear on entering FETCH/MEM and on ack; after TIMEOUT consecutive no-ack cycles, fault[1] SHALL set and next state SHALL be HALT; ack on the limit cycle wins.
REQ-015 retired SHALL increment on every EXEC->FETCH exit and every MEM ack (illegal ops included, HALT excluded), wrapping mod 2^CNT_W.
REQ-016 mem_ack outside FETCH/MEM SHALL be ignored; fault bits SHALL stay set until rst.

Reset
REQ-017 rst SHALL force next state FETCH and clear retired, fault and the timeout counter on the same edge, aborting any MEM transfer with no write; after that edge the outputs SHALL follow REQ-004/REQ-005 for FETCH (mem_req=1, all other outputs 0).

Verification
REQ-018 ir=0x12C8 (ADD r1,r3,r1), ack in first FETCH cycle -> EXEC: aa=3, ba=1, da=1, wr=1, fs=00010, ps=01; retired=1.
REQ-019 ir=0x64F0 (ADDI r2,0xF0), DW=16 -> k=0xFFF0 if IMM_SIGNED=1, k=0x00F0 if 0; mux_k=1, aa=da=2.
REQ-020 LD with mem_ack 3 cycles late in MEM -> mem_req high 4 cycles; wr=1, mux_mem=1 only in ack cycle.
REQ-021 TIMEOUT=15, mem_ack=0 in FETCH -> after 15 cycles halted=1, fault=10, mem_req=0, held until rst.
REQ-022 ir=0xC000 then 0xF000 -> fault=01, ps=01, retired+1; then halted=1, retired unchanged.
REQ-023 rst during ST in MEM -> after edge: FETCH, mem_we=0, retired=0, fault=00.
